qos_scheduler: RTL

//  Output scheduler for the QoS block. Decides which virtual-channel FIFO is read next and drives one-hot pops to the

---
 rtl/qos_scheduler_pkg.sv | 25 ++
 rtl/qos_scheduler_rr_priority_picker.sv | 28 ++
 rtl/qos_scheduler.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/qos_scheduler_pkg.sv
// Shared types for the QoS output scheduler: FSM states, arbitration modes
// and the mode decoder that folds unused encodings onto round-robin.
package qos_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_SERVE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      MODO_RR    = 2'd0,
      MODO_WRR   = 2'd1,
      MODO_TABLA = 2'd2
   } modo_e;

   function automatic modo_e decode_mode(input int m);
      case (m)
         1:       decode_mode = MODO_WRR;
         2:       decode_mode = MODO_TABLA;
         default: decode_mode = MODO_RR;
      endcase
   endfunction

endpackage

// File: rtl/qos_scheduler_rr_priority_picker.sv
// Rotating-priority search: returns the first asserted request at or after
// the start pointer, wrapping around N request bits.
module qos_scheduler_rr_priority_picker #(
   parameter int N = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic          hit,
   output logic [IW-1:0] idx
);

   int c;

   always_comb begin
      hit = 1'b0;
      idx = '0;
      c   = 0;
      for (int k = 0; k < N; k++) begin
         c = (int'(start) + k) % N;
         if (!hit && req[IW'(c)]) begin
            hit = 1'b1;
            idx = IW'(c);
         end
      end
   end

endmodule

// File: rtl/qos_scheduler.sv
// QoS output scheduler: chooses the next VC FIFO to read (RR, WRR or table
// driven) and drives one-hot pops while the downstream consumer is ready.
module qos_scheduler
   import qos_scheduler_pkg::*;
#(
   parameter int QUEUE_QUANTITY    = 4,
   parameter int MAX_WEIGHT        = 64,
   parameter int TABLE_SIZE        = 8,
   parameter int TIPOS_ROUND_ROBIN = 3,
   localparam int VW = $clog2(QUEUE_QUANTITY),
   localparam int WW = $clog2(MAX_WEIGHT),
   localparam int TW = $clog2(TABLE_SIZE),
   localparam int MW = $clog2(TIPOS_ROUND_ROBIN)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enb,
   input  logic                         iniciar,
   input  logic [MW-1:0]                mem_seleccion_roundRobin,
   input  logic [QUEUE_QUANTITY*WW-1:0] mem_pesos,
   input  logic [TABLE_SIZE*WW-1:0]     mem_pesosArbitraje,
   input  logic [TABLE_SIZE*VW-1:0]     mem_selecciones,
   input  logic [QUEUE_QUANTITY-1:0]    fifo_empty,
   input  logic                         rd_en,
   output logic [QUEUE_QUANTITY-1:0]    pop,
   output logic [VW-1:0]                vc_sel,
   output logic                         grant_valid,
   output logic                         idle
);

   state_e                      state_q, state_d;
   logic [VW-1:0]               rr_ptr_q, rr_ptr_d;
   logic [TW-1:0]               tbl_ptr_q, tbl_ptr_d;
   logic [WW-1:0]               credit_q, credit_d;
   logic [TW:0]                 miss_q, miss_d;
   logic [VW-1:0]               vc_sel_q, vc_sel_d;
   logic [MW-1:0]               mode_q, mode_d;
   logic [QUEUE_QUANTITY*WW-1:0] pesos_q, pesos_d;
   logic [TABLE_SIZE*WW-1:0]    arb_q, arb_d;
   logic [TABLE_SIZE*VW-1:0]    sel_q, sel_d;

   logic                        is_wrr, is_tbl;
   logic [QUEUE_QUANTITY-1:0]   req;
   logic                        pick_hit;
   logic [VW-1:0]               pick_idx;
   logic [WW-1:0]               ent_w;
   logic [VW-1:0]               ent_vc;
   logic                        ent_ok;
   logic                        serve_empty;
   logic                        leave;
   logic [QUEUE_QUANTITY-1:0]   pop_c;

   // Out-of-range VC ids read as empty, which makes them ineligible.
   function automatic logic vc_empty(input logic [VW-1:0] vc,
                                     input logic [QUEUE_QUANTITY-1:0] fe);
      vc_empty = 1'b1;
      for (int i = 0; i < QUEUE_QUANTITY; i++)
         if (int'(vc) == i) vc_empty = fe[i];
   endfunction

   function automatic logic [WW-1:0] vc_weight(input logic [VW-1:0] vc,
                                               input logic [QUEUE_QUANTITY*WW-1:0] w);
      vc_weight = '0;
      for (int i = 0; i < QUEUE_QUANTITY; i++)
         if (int'(vc) == i) vc_weight = w[i*WW +: WW];
   endfunction

   function automatic logic [QUEUE_QUANTITY-1:0] onehot(input logic [VW-1:0] vc);
      onehot = '0;
      for (int i = 0; i < QUEUE_QUANTITY; i++)
         onehot[i] = (int'(vc) == i);
   endfunction

   assign is_wrr = (decode_mode(int'(mode_q)) == MODO_WRR);
   assign is_tbl = (decode_mode(int'(mode_q)) == MODO_TABLA);

   always_comb begin
      for (int i = 0; i < QUEUE_QUANTITY; i++)
         req[i] = !fifo_empty[i] && (!is_wrr || (pesos_q[i*WW +: WW] != '0));
   end

   qos_scheduler_rr_priority_picker #(
      .N (QUEUE_QUANTITY)
   ) u_picker (
      .req   (req),
      .start (rr_ptr_q),
      .hit   (pick_hit),
      .idx   (pick_idx)
   );

   assign ent_w  = arb_q[int'(tbl_ptr_q)*WW +: WW];
   assign ent_vc = sel_q[int'(tbl_ptr_q)*VW +: VW];
   assign ent_ok = (ent_w != '0) && !vc_empty(ent_vc, fifo_empty);

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      tbl_ptr_d   = tbl_ptr_q;
      credit_d    = credit_q;
      miss_d      = miss_q;
      vc_sel_d    = vc_sel_q;
      mode_d      = mode_q;
      pesos_d     = pesos_q;
      arb_d       = arb_q;
      sel_d       = sel_q;
      pop_c       = '0;
      serve_empty = 1'b0;
      leave       = 1'b0;

      if (enb) begin
         if (iniciar) begin
            mode_d    = mem_seleccion_roundRobin;
            pesos_d   = mem_pesos;
            arb_d     = mem_pesosArbitraje;
            sel_d     = mem_selecciones;
            rr_ptr_d  = '0;
            tbl_ptr_d = '0;
            credit_d  = '0;
            miss_d    = '0;
            state_d   = ST_SCAN;
         end else begin
            case (state_q)
               ST_SCAN: begin
                  if (is_tbl) begin
                     if (ent_ok) begin
                        vc_sel_d = ent_vc;
                        credit_d = ent_w;
                        miss_d   = '0;
                        state_d  = ST_SERVE;
                     end else begin
                        tbl_ptr_d = (tbl_ptr_q == TW'(TABLE_SIZE-1)) ? '0 : tbl_ptr_q + TW'(1);
                        if (miss_q != (TW+1)'(TABLE_SIZE)) miss_d = miss_q + (TW+1)'(1);
                     end
                  end else if (pick_hit) begin
                     vc_sel_d = pick_idx;
                     credit_d = is_wrr ? vc_weight(pick_idx, pesos_q) : WW'(1);
                     state_d  = ST_SERVE;
                  end
               end
               ST_SERVE: begin
                  serve_empty = vc_empty(vc_sel_q, fifo_empty);
                  if (serve_empty) begin
                     leave    = 1'b1;
                     credit_d = '0;
                  end else if (rd_en) begin
                     pop_c = onehot(vc_sel_q);
                     if (credit_q != '0) credit_d = credit_q - WW'(1);
                     if (credit_q <= WW'(1)) leave = 1'b1;
                  end
                  if (leave) begin
                     state_d = ST_SCAN;
                     if (is_tbl)
                        tbl_ptr_d = (tbl_ptr_q == TW'(TABLE_SIZE-1)) ? '0 : tbl_ptr_q + TW'(1);
                     else
                        rr_ptr_d = (vc_sel_q == VW'(QUEUE_QUANTITY-1)) ? '0 : vc_sel_q + VW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= '0;
         tbl_ptr_q <= '0;
         credit_q  <= '0;
         miss_q    <= '0;
         vc_sel_q  <= '0;
         mode_q    <= '0;
         pesos_q   <= '0;
         arb_q     <= '0;
         sel_q     <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         tbl_ptr_q <= tbl_ptr_d;
         credit_q  <= credit_d;
         miss_q    <= miss_d;
         vc_sel_q  <= vc_sel_d;
         mode_q    <= mode_d;
         pesos_q   <= pesos_d;
         arb_q     <= arb_d;
         sel_q     <= sel_d;
      end
   end

   assign pop         = pop_c;
   assign vc_sel      = vc_sel_q;
   assign grant_valid = (state_q == ST_SERVE);
   // Table mode only reports idle once a full lap of the table found nothing.
   assign idle        = (state_q == ST_IDLE) ||
                        ((state_q == ST_SCAN) &&
                         (is_tbl ? (miss_q == (TW+1)'(TABLE_SIZE)) : !pick_hit));

endmodule
